// File: rtl/pe_pkg.sv
// Shared constants and types for the 32-input priority-encoder path:
// request vector/index types and the grant-offer state encoding.
package pe_pkg;

    localparam int SIZE  = 5;
    localparam int WIDTH = 2 ** SIZE;

    typedef logic [WIDTH-1:0] req_vec_t;
    typedef logic [SIZE-1:0]  req_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } grant_state_t;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports the highest set bit of vec_i.
// It sits beside the tracker in the parent and closes the enc_vec/enc_idx loop.
module priority_encoder #(
    parameter int SIZE  = 5,
    parameter int WIDTH = 2 ** SIZE
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [SIZE-1:0]  idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Ascending scan so the highest set index is the last one written.
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o   = SIZE'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_tracker.sv
// Pending/mask register ahead of the priority encoder; captures the encoder
// result and offers it as a grant, clearing the granted bit on acceptance.
module irq_pending_tracker
    import pe_pkg::*;
#(
    parameter int SIZE  = pe_pkg::SIZE,
    parameter int CNT_W = 16,
    localparam int WIDTH = 2 ** SIZE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WIDTH-1:0]  req_i,
    input  logic              mask_we_i,
    input  logic [WIDTH-1:0]  mask_i,
    output logic [WIDTH-1:0]  enc_vec_o,
    input  logic [SIZE-1:0]   enc_idx_i,
    input  logic              enc_valid_i,
    output logic              grant_valid_o,
    output logic [SIZE-1:0]   grant_idx_o,
    input  logic              grant_ready_i,
    output logic              ovf_o,
    input  logic              ovf_clr_i,
    output logic [CNT_W-1:0]  grant_cnt_o
);

    // Handshake: a grant transfers on a rising edge where grant_valid_o and
    // grant_ready_i are both high; grant_idx_o is stable while valid is high
    // and grant_ready_i has no effect while valid is low.

    grant_state_t     state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] mask_q;
    logic [SIZE-1:0]  grant_idx_q;
    logic             capture;
    logic             handshake;
    logic [WIDTH-1:0] clr;
    logic             ovf_q;
    logic             ovf_set;
    logic [CNT_W-1:0] cnt_q;

    assign enc_vec_o     = pending_q & mask_q;
    assign grant_valid_o = (state_q == OFFER);
    assign grant_idx_o   = grant_idx_q;
    assign ovf_o         = ovf_q;
    assign grant_cnt_o   = cnt_q;

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enc_valid_i) begin
                    capture = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (grant_ready_i) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request landing on the bit being cleared keeps it pending and is
    // not an overrun, since the earlier event has just been consumed.
    assign clr       = handshake ? (WIDTH'(1) << grant_idx_q) : '0;
    assign pending_d = (pending_q & ~clr) | req_i;
    assign ovf_set   = |(req_i & pending_q & ~clr);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            mask_q      <= '1;
            grant_idx_q <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (mask_we_i) begin
                mask_q <= mask_i;
            end
            if (capture) begin
                grant_idx_q <= enc_idx_i;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
            if (handshake) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/irq_pending_tracker.md
Name: irq_pending_tracker

Overview:
- Upstream stage of the 32-input priority encoder (SIZE=5).
- Collects single-cycle request events into a pending register and applies an enable mask.
- Presents pending&mask to the encoder, captures the encoder's index/valid, and offers it as a grant over a valid/ready handshake. The granted pending bit clears on acceptance.
- Sits between the request sources and the dispatch logic; the encoder is instantiated beside it in the parent.

Parameters:
- SIZE, 5, log2 of request count; WIDTH = 2**SIZE request lines.
- CNT_W, 16, width of the completed-grant counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_i  in  WIDTH  event pulses; bit i high for a cycle sets pending[i].
- mask_we_i  in  1  mask write strobe.
- mask_i  in  WIDTH  new mask value, loaded when mask_we_i=1.
- enc_vec_o  out  WIDTH  pending & mask, driven to the encoder input.
- enc_idx_i  in  SIZE  encoder index result.
- enc_valid_i  in  1  encoder valid (pending&mask nonzero).
- grant_valid_o  out  1  grant offered.
- grant_idx_o  out  SIZE  granted request index.
- grant_ready_i  in  1  consumer accepts grant.
- ovf_o  out  1  sticky overrun flag.
- ovf_clr_i  in  1  clears ovf_o.
- grant_cnt_o  out  CNT_W  completed-grant count.

Behaviour:
- Reset (rst_ni=0 at an edge) loads these values:
  - pending = 0; mask = all ones; state = IDLE.
  - grant_valid_o = 0; grant_idx_o = 0.
  - ovf_o = 0; grant_cnt_o = 0.
- Reset mid-offer abandons the grant: no bit clear, no count.
- enc_vec_o = pending & mask, purely combinational from registers. It never depends on req_i in the same cycle.
- Pending update each edge: pending_next = (pending & ~clr) | req_i.
  - clr is one-hot at grant_idx_o when a handshake completes this cycle, else zero.
  - A new req on the same bit as the clear wins: the bit stays set.
- Masked bits stay pending and are invisible to the encoder. Unmasking later exposes them.
- Mask load takes effect at the next edge. A new mask does not alter an offer already in progress.
- Overrun: ovf_o sets when req_i[i]=1, pending[i]=1 and bit i is not being cleared this cycle.
  - The event is merged, not counted.
  - ovf_clr_i clears ovf_o; if a set condition coincides, set wins.
- FSM with two states, IDLE and OFFER:
  - IDLE: grant_valid_o=0. If enc_valid_i=1, register grant_idx_o <= enc_idx_i and go to OFFER; else stay.
  - OFFER: grant_valid_o=1 and grant_idx_o held stable. If grant_ready_i=1, the handshake completes:
    - clear pending[grant_idx_o];
    - grant_cnt_o += 1, wrapping modulo 2**CNT_W;
    - return to IDLE.
  - Else OFFER holds indefinitely.
- The mandatory IDLE cycle after each grant lets the encoder see the updated vector. This gives a maximum rate of one grant per 2 cycles.
- Latency: req_i sampled at edge N sets pending at N; the index is captured at N+1; grant_valid_o is high in the cycle after N+1.
- Priority follows the encoder: the highest set index wins. The tracker never reorders.
- The enc_idx_i/enc_valid_i inputs are trusted. If enc_valid_i=0, IDLE holds regardless of enc_idx_i.
- grant_ready_i is ignored in IDLE.

Decomposition:
- Shared package pe_pkg holds:
  - SIZE and WIDTH constants;
  - typedef logic [WIDTH-1:0] req_vec_t;
  - typedef logic [SIZE-1:0] req_idx_t;
  - enum grant_state_t {IDLE, OFFER}.
- No sub-module inside the tracker. The priority encoder stays a sibling instance wired in the parent, and the bench instantiates both.

Test Plan:
- Reset, then req_i=32'h0000_0010 for one cycle -> enc_vec_o=32'h10 next cycle; grant_valid_o=1 with grant_idx_o=4 two cycles after the pulse. With ready=1, pending clears and grant_cnt_o=1.
- req_i=32'h8000_0001 in one cycle, ready held 1 -> grants 31 then 0 on cycles spaced 2 apart; enc_vec_o ends at 0; grant_cnt_o=2.
- Offer idx=3 with ready=0 for 5 cycles while req_i sets bit 9 -> grant_idx_o stays 3 throughout. After ready, the next grant is 9.
- Bit 7 pending, then req_i[7] pulses again -> ovf_o=1. ovf_clr_i clears it. req_i[7] coincident with the clear handshake of idx 7 -> bit stays pending and ovf_o stays 0.
- mask_we_i with mask_i=32'hFFFF_FF7F, then req_i[7] -> enc_vec_o=0 and no grant. Writing mask 32'hFFFF_FFFF -> grant idx 7.
- rst_ni=0 during OFFER of idx 2 -> next cycle grant_valid_o=0, pending=0, grant_cnt_o=0. Preloading grant_cnt_o near max (2**CNT_W-1 grants) shows it wraps to 0.
